// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register-file completer.
// Build option APB_REGFILE_PROT_CHECK_EN is consumed by apb_regfile_slave.
package apb_regfile_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam int unsigned CNT_W = 4;

   localparam int unsigned PPROT_PRIV_BIT  = 0;
   localparam int unsigned PPROT_NSEC_BIT  = 1;
   localparam int unsigned PPROT_INSTR_BIT = 2;

   function automatic int unsigned strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned byte_off_w(input int unsigned data_w);
      return (data_w == 32) ? 2 : ((data_w == 16) ? 1 : 0);
   endfunction

endpackage

// File: rtl/apb_regfile_byte_reg.sv
// One DATA_W register with an independent load enable per byte lane.
// Each lane has its own reset value slice taken from RESET_VAL.
module apb_regfile_byte_reg
   import apb_regfile_pkg::*;
#(
   parameter int unsigned        DATA_W    = 32,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0,
   localparam int unsigned       STRB_W    = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [STRB_W-1:0] lane_en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] q_o
);

   for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            lane_q <= RESET_VAL[gi*8 +: 8];
         end else if (lane_en_i[gi]) begin
            lane_q <= data_i[gi*8 +: 8];
         end
      end

      assign q_o[gi*8 +: 8] = lane_q;
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer with NUM_REGS byte-strobed registers and programmable wait states.
// Define APB_REGFILE_PROT_CHECK_EN to reject unprivileged accesses to register 0.
module apb_regfile_slave
   import apb_regfile_pkg::*;
#(
   parameter int unsigned        ADDR_W      = 32,
   parameter int unsigned        DATA_W      = 32,
   parameter int unsigned        NUM_REGS    = 8,
   parameter int unsigned        WAIT_CYCLES = 0,
   parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
   localparam int unsigned       STRB_W      = DATA_W / 8
) (
   input  logic                         PCLK,
   input  logic                         PRESETn,
   input  logic                         PSEL,
   input  logic                         PENABLE,
   input  logic [ADDR_W-1:0]            PADDR,
   input  logic                         PWRITE,
   input  logic [DATA_W-1:0]            PWDATA,
   input  logic [STRB_W-1:0]            PSTRB,
   input  logic [2:0]                   PPROT,
   output logic [DATA_W-1:0]            PRDATA,
   output logic                         PREADY,
   output logic                         PSLVERR,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic [NUM_REGS-1:0]          wr_pulse_o
);

   localparam int unsigned OFF_W = byte_off_w(DATA_W);

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [NUM_REGS-1:0]  pulse_q;
   logic [NUM_REGS-1:0]  pulse_d;
   logic [NUM_REGS-1:0]  reg_sel;
   logic [ADDR_W-1:0]    idx;
   logic                 misaligned;
   logic                 range_err;
   logic                 prot_err;
   logic                 err;
   logic                 complete;
   logic                 do_write;
   logic [DATA_W-1:0]    rd_mux;
   logic                 prot_unused;

   assign idx        = PADDR >> OFF_W;
   assign misaligned = (PADDR & ADDR_W'(STRB_W - 1)) != '0;
   assign range_err  = idx >= ADDR_W'(NUM_REGS);

`ifdef APB_REGFILE_PROT_CHECK_EN
   assign prot_err = !PPROT[PPROT_PRIV_BIT] && (idx == '0);
`else
   assign prot_err = 1'b0;
`endif
   assign prot_unused = ^PPROT;

   assign err      = misaligned | range_err | prot_err;
   assign PREADY   = (state_q == ACCESS) && (cnt_q == '0);
   assign complete = PREADY && PSEL;
   assign do_write = complete && PWRITE && !err;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  state_q <= ACCESS;
                  cnt_q   <= CNT_W'(WAIT_CYCLES);
               end
            end
            ACCESS: begin
               // Losing PSEL mid-transfer abandons it without side effects.
               if (!PSEL) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign pulse_d = do_write ? reg_sel : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         pulse_q <= '0;
      end else begin
         pulse_q <= pulse_d;
      end
   end

   assign wr_pulse_o = pulse_q;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign reg_sel[gi] = (idx == ADDR_W'(gi));

      apb_regfile_byte_reg #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_reg (
         .clk_i     (PCLK),
         .rst_ni    (PRESETn),
         .lane_en_i ({STRB_W{do_write && reg_sel[gi]}} & PSTRB),
         .data_i    (PWDATA),
         .q_o       (regs_o[gi*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (reg_sel[i]) begin
            rd_mux = regs_o[i*DATA_W +: DATA_W];
         end
      end
   end

   assign PRDATA  = (PREADY && !PWRITE && !err) ? rd_mux : '0;
   assign PSLVERR = PREADY && err;

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- Parametrised APB4 completer holding NUM_REGS read/write registers of DATA_W bits each.
- Inserts a programmable number of wait states per transfer.
- Applies PSTRB byte-lane masking on writes.
- Signals PSLVERR on out-of-range or misaligned addresses.
- Sits behind the APB interconnect; register contents are exported flat to the block's hardware consumers.

Parameters:
- ADDR_W, 32, width of PADDR.
- DATA_W, 32, width of PWDATA/PRDATA; must be 8, 16 or 32; byte lanes STRB_W = DATA_W/8.
- NUM_REGS, 8, number of registers; must be >= 1.
- WAIT_CYCLES, 0, wait states inserted in the access phase (0..15).
- RESET_VAL, 0, reset value of every register (DATA_W bits).

Ports:
- PCLK  input  1  APB clock; all state updates on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PADDR  input  ADDR_W  byte address.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  DATA_W  write data.
- PSTRB  input  STRB_W  write byte strobes.
- PPROT  input  3  protection attributes.
- PRDATA  output  DATA_W  read data, valid when PREADY=1.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response, valid when PREADY=1.
- regs_o  output  NUM_REGS*DATA_W  flat register contents; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse_o  output  NUM_REGS  one-cycle pulse on the cycle after a completed, error-free write to reg i.

Behaviour:
- Clock and reset: one clock (PCLK). Reset is asynchronous and active-low (PRESETn).
- On reset:
  - state=IDLE, wait counter=0.
  - all registers = RESET_VAL; wr_pulse_o = 0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
- Decode:
  - index = PADDR >> log2(STRB_W).
  - Misaligned when PADDR[log2(STRB_W)-1:0] != 0 (never misaligned for DATA_W=8).
  - Error when index >= NUM_REGS or misaligned.
- FSM states:
  - IDLE: PSEL=1 and PENABLE=0 (setup phase) -> ACCESS, counter loaded with WAIT_CYCLES.
  - ACCESS, PSEL=1, PENABLE=1, counter != 0: counter decrements, PREADY=0.
  - ACCESS, counter == 0: PREADY=1 (decoded combinationally from registered state/counter). Transfer completes at that edge; state -> IDLE.
  - ACCESS with PSEL=0 (protocol violation): -> IDLE, no write, no pulse.
- Latency: a transfer completes in 2+WAIT_CYCLES cycles (setup + access). Back-to-back transfers restart from IDLE with a new setup phase.
- Write on completion edge, no error: for each lane b with PSTRB[b]=1, reg[index][8b+7:8b] <= PWDATA[8b+7:8b]. Lanes with strobe 0 are unchanged. PSTRB=0 still completes, still pulses wr_pulse_o, with no data change.
- Read: PRDATA = reg[index] while PREADY=1 and PWRITE=0 and no error; otherwise 0. PSTRB is ignored for reads.
- PSLVERR = error flag while PREADY=1, else 0. On error: no write, no pulse, PRDATA=0.
- Reset asserted mid-transfer: immediate return to the reset state; the pending write is dropped.
- Address/data/control are sampled at the completion edge only; changes during wait states are not required to be tolerated (protocol forbids them).

Optional Feature:
- Macro APB_REGFILE_PROT_CHECK_EN.
- Defined: any transfer with PPROT[0]=0 (unprivileged) targeting index 0 completes with PSLVERR=1, no write, PRDATA=0.
- Undefined: PPROT is ignored entirely; port remains present.

Decomposition:
- Package apb_regfile_pkg:
  - state enum (IDLE, ACCESS).
  - localparam helpers STRB_W and log2 byte offset.
  - APB PPROT bit-index constants.
- One sub-module, apb_regfile_byte_reg: a single DATA_W register with per-lane enable and reset value, instantiated NUM_REGS times.
- Address decode and FSM stay in the top module.

Test Plan:
- WAIT_CYCLES=0, write 0xDEADBEEF to 0x04 with PSTRB=0xF, then read 0x04 -> PREADY high in the 2nd cycle of each transfer; PRDATA=0xDEADBEEF; wr_pulse_o[1] pulses once.
- Reg2=0x11223344, write 0xAABBCCDD with PSTRB=0x5 -> reg2 reads 0x11BB33DD.
- WAIT_CYCLES=3, single read -> PREADY low for 3 access cycles, high on the 4th; total 5 cycles.
- Read from 0x20 with NUM_REGS=8, and from 0x02 -> PSLVERR=1, PRDATA=0, no register changes, no pulse.
- Assert PRESETn low during the wait states of a write of 0x12345678 to 0x08 -> reg2=RESET_VAL, PREADY=0, FSM in IDLE; the next transfer behaves normally.
- With APB_REGFILE_PROT_CHECK_EN, write 0xFF to 0x00 with PPROT=3'b000 -> PSLVERR=1, reg0 unchanged; the same write with PPROT=3'b001 succeeds.
